// File: rtl/id_ex_reg_pkg.sv
// Shared widths and local encodings for the ID/EX pipeline register.
// The bubble's ALU op is the all-zero encoding (ADD).
package id_ex_reg_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int ALU_OP_W     = 4;

    localparam logic [REG_ADDR_W-1:0] REG_X0      = '0;
    localparam logic [ALU_OP_W-1:0]   ALU_OP_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0]   BUBBLE_ALU_OP = ALU_OP_ADD;

    // True when an operand the instruction really reads matches the producing register.
    function automatic logic src_match(input logic uses,
                                       input logic [REG_ADDR_W-1:0] src,
                                       input logic [REG_ADDR_W-1:0] rd);
        return uses && (src == rd);
    endfunction

endpackage

// File: rtl/id_ex_reg_load_use_detector.sv
// Load-use hazard equation: a load in EX whose destination is read by the valid ID instruction.
// A flush kills the ID instruction, so it can never stall.
module id_ex_reg_load_use_detector
    import id_ex_reg_pkg::*;
(
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  id_valid,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    output logic                  load_use_stall
);

    logic load_in_ex;
    logic src_hit;

    assign load_in_ex = ex_valid && ex_mem_read && (ex_rd_addr != REG_X0);
    assign src_hit    = src_match(id_uses_rs1, id_rs1_addr, ex_rd_addr)
                     || src_match(id_uses_rs2, id_rs2_addr, ex_rd_addr);

    assign load_use_stall = !flush && load_in_ex && id_valid && src_hit;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and a bubble counter.
// Priority per edge: rst, flush, hold, load-use stall, normal load.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  hold,
    input  logic                  id_valid,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  id_alu_src,
    input  logic                  id_branch,
    input  logic                  id_jump,
    input  logic [ALU_OP_W-1:0]   id_alu_op,
    output logic                  id_ex_valid,
    output logic [XLEN-1:0]       id_ex_pc,
    output logic [REG_ADDR_W-1:0] id_ex_rs1_addr,
    output logic [REG_ADDR_W-1:0] id_ex_rs2_addr,
    output logic [REG_ADDR_W-1:0] id_ex_rd_addr,
    output logic [XLEN-1:0]       id_ex_rs1_data,
    output logic [XLEN-1:0]       id_ex_rs2_data,
    output logic [XLEN-1:0]       id_ex_imm,
    output logic                  id_ex_reg_write,
    output logic                  id_ex_mem_read,
    output logic                  id_ex_mem_write,
    output logic                  id_ex_mem_to_reg,
    output logic                  id_ex_alu_src,
    output logic                  id_ex_branch,
    output logic                  id_ex_jump,
    output logic [ALU_OP_W-1:0]   id_ex_alu_op,
    output logic                  load_use_stall,
    output logic [CNT_W-1:0]      bubble_count
);

    logic insert_bubble;
    logic load_en;
    logic count_en;

    id_ex_reg_load_use_detector u_load_use_detector (
        .flush          (flush),
        .ex_valid       (id_ex_valid),
        .ex_mem_read    (id_ex_mem_read),
        .ex_rd_addr     (id_ex_rd_addr),
        .id_valid       (id_valid),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .id_rs1_addr    (id_rs1_addr),
        .id_rs2_addr    (id_rs2_addr),
        .load_use_stall (load_use_stall)
    );

    // Flush overrides hold; a held stall is only counted once the hold releases.
    assign insert_bubble = rst || flush || (!hold && load_use_stall);
    assign load_en       = !rst && !flush && !hold && !load_use_stall;
    assign count_en      = !rst && !flush && !hold && load_use_stall;

    always_ff @(posedge clk) begin
        if (insert_bubble) begin
            id_ex_valid      <= 1'b0;
            id_ex_pc         <= '0;
            id_ex_rs1_addr   <= REG_X0;
            id_ex_rs2_addr   <= REG_X0;
            id_ex_rd_addr    <= REG_X0;
            id_ex_rs1_data   <= '0;
            id_ex_rs2_data   <= '0;
            id_ex_imm        <= '0;
            id_ex_reg_write  <= 1'b0;
            id_ex_mem_read   <= 1'b0;
            id_ex_mem_write  <= 1'b0;
            id_ex_mem_to_reg <= 1'b0;
            id_ex_alu_src    <= 1'b0;
            id_ex_branch     <= 1'b0;
            id_ex_jump       <= 1'b0;
            id_ex_alu_op     <= BUBBLE_ALU_OP;
        end else if (load_en) begin
            id_ex_valid      <= id_valid;
            id_ex_pc         <= id_pc;
            id_ex_rs1_addr   <= id_rs1_addr;
            id_ex_rs2_addr   <= id_rs2_addr;
            id_ex_rd_addr    <= id_rd_addr;
            id_ex_rs1_data   <= id_rs1_data;
            id_ex_rs2_data   <= id_rs2_data;
            id_ex_imm        <= id_imm;
            id_ex_reg_write  <= id_reg_write;
            id_ex_mem_read   <= id_mem_read;
            id_ex_mem_write  <= id_mem_write;
            id_ex_mem_to_reg <= id_mem_to_reg;
            id_ex_alu_src    <= id_alu_src;
            id_ex_branch     <= id_branch;
            id_ex_jump       <= id_jump;
            id_ex_alu_op     <= id_alu_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_count <= '0;
        end else if (count_en) begin
            bubble_count <= bubble_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed load-use/flush/hold/reset scenarios plus randomized traffic,
// all compared every cycle against a behavioural model of the ID/EX stage.
module tb_id_ex_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        asrc;
        logic        br;
        logic        jmp;
        logic [3:0]  op;
    } ex_t;

    logic clk;
    logic rst, flush, hold, u1, u2;
    ex_t  id_in;

    logic        o_valid, o_rw, o_mr, o_mw, o_m2r, o_asrc, o_br, o_jmp;
    logic [31:0] o_pc, o_d1, o_d2, o_imm;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic [3:0]  o_op;
    logic        stall;
    logic [31:0] bcount;
    ex_t         dut_out;

    // Behavioural model state: what EX must hold, and the bubble tally.
    ex_t         m;
    logic [31:0] m_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    id_ex_reg #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .hold(hold),
        .id_valid(id_in.valid), .id_pc(id_in.pc),
        .id_rs1_addr(id_in.rs1), .id_rs2_addr(id_in.rs2), .id_rd_addr(id_in.rd),
        .id_uses_rs1(u1), .id_uses_rs2(u2),
        .id_rs1_data(id_in.d1), .id_rs2_data(id_in.d2), .id_imm(id_in.imm),
        .id_reg_write(id_in.rw), .id_mem_read(id_in.mr), .id_mem_write(id_in.mw),
        .id_mem_to_reg(id_in.m2r), .id_alu_src(id_in.asrc), .id_branch(id_in.br),
        .id_jump(id_in.jmp), .id_alu_op(id_in.op),
        .id_ex_valid(o_valid), .id_ex_pc(o_pc),
        .id_ex_rs1_addr(o_rs1), .id_ex_rs2_addr(o_rs2), .id_ex_rd_addr(o_rd),
        .id_ex_rs1_data(o_d1), .id_ex_rs2_data(o_d2), .id_ex_imm(o_imm),
        .id_ex_reg_write(o_rw), .id_ex_mem_read(o_mr), .id_ex_mem_write(o_mw),
        .id_ex_mem_to_reg(o_m2r), .id_ex_alu_src(o_asrc), .id_ex_branch(o_br),
        .id_ex_jump(o_jmp), .id_ex_alu_op(o_op),
        .load_use_stall(stall), .bubble_count(bcount)
    );

    assign dut_out = '{valid: o_valid, pc: o_pc, rs1: o_rs1, rs2: o_rs2, rd: o_rd,
                       d1: o_d1, d2: o_d2, imm: o_imm, rw: o_rw, mr: o_mr, mw: o_mw,
                       m2r: o_m2r, asrc: o_asrc, br: o_br, jmp: o_jmp, op: o_op};

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic exp_stall();
        logic hit;
        hit = (u1 && id_in.rs1 == m.rd) || (u2 && id_in.rs2 == m.rd);
        return !flush && m.valid && m.mr && (m.rd != 5'd0) && id_in.valid && hit;
    endfunction

    always @(posedge clk) begin
        logic st;
        st = exp_stall();
        if (rst) begin
            m = '0;
            m_cnt = 0;
        end else if (flush) begin
            m = '0;
        end else if (hold) begin
            m = m;
        end else if (st) begin
            m = '0;
            m_cnt = m_cnt + 1;
        end else begin
            m = id_in;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (dut_out !== m) begin
                errors++;
                $display("FAIL regs t=%0t actual=%h required=%h", $time, dut_out, m);
            end
            checks++;
            if (bcount !== m_cnt) begin
                errors++;
                $display("FAIL bubble_count t=%0t actual=%0d required=%0d", $time, bcount, m_cnt);
            end
            checks++;
            if (stall !== exp_stall()) begin
                errors++;
                $display("FAIL load_use_stall t=%0t actual=%b required=%b", $time, stall, exp_stall());
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic use1, input logic use2,
                             input logic rw, input logic mr);
        id_in.valid = 1'b1;
        id_in.pc    = pc;
        id_in.rs1   = rs1;
        id_in.rs2   = rs2;
        id_in.rd    = rd;
        id_in.d1    = $urandom;
        id_in.d2    = $urandom;
        id_in.imm   = $urandom;
        id_in.rw    = rw;
        id_in.mr    = mr;
        id_in.mw    = 1'b0;
        id_in.m2r   = mr;
        id_in.asrc  = mr;
        id_in.br    = 1'b0;
        id_in.jmp   = 1'b0;
        id_in.op    = 4'($urandom_range(0, 15));
        u1 = use1;
        u2 = use2;
    endtask

    task automatic lu_pair();
        set_instr(32'h300, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc();
        set_instr(32'h304, 5'd3, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        cyc();
    endtask

    initial begin
        rst = 1; flush = 0; hold = 0; u1 = 0; u2 = 0;
        id_in = '0;
        m = '0;
        m_cnt = 0;
        cyc();
        cyc();
        cmp_en = 1;
        rst = 0;
        lit("reset_valid", {31'd0, o_valid}, 32'd0);
        lit("reset_count", bcount, 32'd0);

        // Straight-line ADD x5
        set_instr(32'h100, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        #1 lit("add_stall", {31'd0, stall}, 32'd0);
        cyc();
        lit("add_rd", {27'd0, o_rd}, 32'd5);
        lit("add_rw", {31'd0, o_rw}, 32'd1);
        lit("add_valid", {31'd0, o_valid}, 32'd1);

        // LW x3 then ADD x4,x3,x1
        set_instr(32'h104, 5'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc();
        set_instr(32'h108, 5'd3, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        #1 lit("lu_stall", {31'd0, stall}, 32'd1);
        cyc();
        lit("lu_bubble_valid", {31'd0, o_valid}, 32'd0);
        lit("lu_bubble_rs1", {27'd0, o_rs1}, 32'd0);
        lit("lu_bubble_rd", {27'd0, o_rd}, 32'd0);
        lit("lu_count", bcount, 32'd1);
        lit("lu_stall_drop", {31'd0, stall}, 32'd0);
        cyc();
        lit("lu_dep_rd", {27'd0, o_rd}, 32'd4);
        lit("lu_dep_pc", o_pc, 32'h108);

        // LW x0 feeding ADD x4,x0,x1
        set_instr(32'h10c, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc();
        set_instr(32'h110, 5'd0, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        #1 lit("x0_no_stall", {31'd0, stall}, 32'd0);
        cyc();
        // LW x3 followed by LUI x3 (no source use)
        set_instr(32'h114, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc();
        set_instr(32'h118, 5'd3, 5'd3, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 lit("lui_no_stall", {31'd0, stall}, 32'd0);
        cyc();

        // Flush beats load-use
        set_instr(32'h11c, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc();
        set_instr(32'h120, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        flush = 1;
        #1 lit("flush_stall", {31'd0, stall}, 32'd0);
        cyc();
        flush = 0;
        lit("flush_valid", {31'd0, o_valid}, 32'd0);
        lit("flush_count", bcount, 32'd1);

        // Hold with changing ID inputs, then hold+flush
        set_instr(32'h200, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            set_instr(32'h400 + 32'(i * 4), 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
            cyc();
            lit("hold_pc", o_pc, 32'h200);
            lit("hold_rd", {27'd0, o_rd}, 32'd7);
        end
        flush = 1;
        cyc();
        flush = 0;
        lit("hold_flush_valid", {31'd0, o_valid}, 32'd0);

        // Hold during a load-use stall: counted only once hold releases
        hold = 0;
        set_instr(32'h500, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc();
        set_instr(32'h504, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        hold = 1;
        #1 lit("hold_lu_stall", {31'd0, stall}, 32'd1);
        cyc();
        lit("hold_lu_stall_kept", {31'd0, stall}, 32'd1);
        lit("hold_lu_count", bcount, 32'd1);
        lit("hold_lu_rd", {27'd0, o_rd}, 32'd3);
        hold = 0;
        cyc();
        lit("hold_lu_count_after", bcount, 32'd2);
        lit("hold_lu_bubble", {31'd0, o_valid}, 32'd0);
        cyc();
        lit("hold_lu_dep_rd", {27'd0, o_rd}, 32'd4);

        // Build up to 7 bubbles, then reset with a valid instruction in EX
        for (int i = 0; i < 5; i++) lu_pair();
        lit("count_seven", bcount, 32'd7);
        lit("pre_reset_valid", {31'd0, o_valid}, 32'd1);
        rst = 1;
        cyc();
        rst = 0;
        lit("rst_valid", {31'd0, o_valid}, 32'd0);
        lit("rst_count", bcount, 32'd0);
        lit("rst_pc", o_pc, 32'd0);
        lit("rst_rd", {27'd0, o_rd}, 32'd0);

        // Randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            id_in.valid = ($urandom_range(0, 7) != 0);
            id_in.pc    = $urandom;
            id_in.rs1   = 5'($urandom_range(0, 3));
            id_in.rs2   = 5'($urandom_range(0, 3));
            id_in.rd    = 5'($urandom_range(0, 3));
            id_in.d1    = $urandom;
            id_in.d2    = $urandom;
            id_in.imm   = $urandom;
            id_in.rw    = 1'($urandom_range(0, 1));
            id_in.mr    = 1'($urandom_range(0, 1));
            id_in.mw    = 1'($urandom_range(0, 1));
            id_in.m2r   = 1'($urandom_range(0, 1));
            id_in.asrc  = 1'($urandom_range(0, 1));
            id_in.br    = 1'($urandom_range(0, 1));
            id_in.jmp   = 1'($urandom_range(0, 1));
            id_in.op    = 4'($urandom_range(0, 15));
            u1 = 1'($urandom_range(0, 1));
            u2 = 1'($urandom_range(0, 1));
            cyc();
        end
        rst = 0; flush = 0; hold = 0;
        cyc();
        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
